async_counter: RTL and testbench

ASYNC_COUNTER -- requirements
Module: async_counter

---
 rtl/async_counter.sv | 65 ++++++
 tb/tb_async_counter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/async_counter.sv
// Up/down counter clocked by the falling edge of the system clock, counting rising
// edges of a foreign-domain count clock, with transparent parallel load.
module async_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             c,
    input  logic             en,
    input  logic             dir,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             co
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             co_q, co_d;
    logic             c_dly_q;
    logic             evt;
    logic [WIDTH-1:0] base;

    // The c history flop deliberately has no reset: it keeps following c during
    // reset so a c level held high across reset release is not taken as a rise.
    always_ff @(negedge clock) begin
        c_dly_q <= c;
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            co_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            co_q  <= co_d;
        end
    end

    // Next state starts from the visible value so a load persists after ld falls;
    // a count event coinciding with ld is consumed without counting.
    always_comb begin
        evt   = c && !c_dly_q;
        base  = ld ? d : cnt_q;
        cnt_d = base;
        co_d  = 1'b0;
        if (evt && en && !ld) begin
            cnt_d = dir ? base + 1'b1 : base - 1'b1;
            co_d  = tc;
        end
    end

    always_comb begin
        if (reset)
            q = '0;
        else if (ld)
            q = d;
        else
            q = cnt_q;
    end

    assign tc = en && ((dir && (q == '1)) || (!dir && (q == '0)));
    assign co = co_q;

endmodule

// File: tb/tb_async_counter.sv
// Self-checking bench for async_counter (WIDTH = 4): directed scenarios plus a
// short random run, with expected counts queued when each c pulse is driven.
module tb_async_counter;
    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         c = 1'b0;
    logic         en = 1'b0;
    logic         dir = 1'b1;
    logic         ld = 1'b0;
    logic [W-1:0] d = '0;
    logic [W-1:0] q;
    logic         tc;
    logic         co;

    async_counter #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .c(c), .en(en), .dir(dir),
        .ld(ld), .d(d), .q(q), .tc(tc), .co(co)
    );

    always #5 clock = ~clock;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] m_cnt = '0;
    logic [W-1:0] exp_q[$];
    logic         exp_co_q[$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_tc(input logic [W-1:0] v, input logic e, input logic up);
        return e && (up ? (v == 4'hF) : (v == 4'h0));
    endfunction

    // One slow c pulse with ld low; q and co are checked one half period after
    // the detecting falling edge, co again a period later.
    task automatic pulse_c(input string tag);
        logic [W-1:0] e_q;
        logic         e_co;
        logic         t;
        @(posedge clock); #1;
        t = model_tc(m_cnt, en, dir);
        check({tag, "_tc"}, {15'd0, tc}, {15'd0, t});
        if (en) m_cnt = dir ? m_cnt + 4'd1 : m_cnt - 4'd1;
        exp_q.push_back(m_cnt);
        exp_co_q.push_back(t);
        c = 1'b1;
        @(posedge clock); #1;
        e_q  = exp_q.pop_front();
        e_co = exp_co_q.pop_front();
        check({tag, "_q"}, {12'd0, q}, {12'd0, e_q});
        check({tag, "_co"}, {15'd0, co}, {15'd0, e_co});
        c = 1'b0;
        @(posedge clock); #1;
        check({tag, "_co_clr"}, {15'd0, co}, 16'd0);
    endtask

    task automatic do_load(input string tag, input logic [W-1:0] val);
        @(posedge clock); #1;
        ld = 1'b1;
        d  = val;
        #1 check({tag, "_transp"}, {12'd0, q}, {12'd0, val});
        @(posedge clock); #1;
        ld = 1'b0;
        d  = ~val;
        #1 check({tag, "_held"}, {12'd0, q}, {12'd0, val});
        m_cnt = val;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_q", {12'd0, q}, 16'd0);
        check("rst_co", {15'd0, co}, 16'd0);
        check("rst_tc", {15'd0, tc}, 16'd0);
        reset = 1'b0;
        m_cnt = '0;

        // Up count through wrap: co only on the 16th event
        en  = 1'b1;
        dir = 1'b1;
        for (int i = 1; i <= 17; i++) pulse_c($sformatf("up%0d", i));

        // Down wrap from a loaded zero
        do_load("ld0", 4'd0);
        dir = 1'b0;
        pulse_c("down_wrap");

        // Transparent load, persistence, then count from it
        do_load("ld9", 4'd9);
        dir = 1'b1;
        pulse_c("after_ld9");

        // ld and a c rise in the same period: load wins, no co
        @(posedge clock); #1;
        ld = 1'b1;
        d  = 4'd3;
        c  = 1'b1;
        @(posedge clock); #1;
        check("sim_co", {15'd0, co}, 16'd0);
        ld = 1'b0;
        #1 check("sim_q", {12'd0, q}, 16'd3);
        c = 1'b0;
        repeat (2) @(posedge clock);
        #1 check("sim_q_hold", {12'd0, q}, 16'd3);
        check("sim_co_hold", {15'd0, co}, 16'd0);
        m_cnt = 4'd3;

        // Enable gating
        en = 1'b0;
        for (int i = 0; i < 5; i++) pulse_c($sformatf("en0_%0d", i));
        check("en0_tc", {15'd0, tc}, 16'd0);
        do_load("ld15", 4'd15);
        en  = 1'b1;
        dir = 1'b1;
        #1 check("tc_up15", {15'd0, tc}, 16'd1);
        dir = 1'b0;
        #1 check("tc_down15", {15'd0, tc}, 16'd0);
        do_load("ld0b", 4'd0);
        #1 check("tc_down0", {15'd0, tc}, 16'd1);

        // Random enable/direction mix
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            en  = 1'($urandom_range(0, 3) != 0);
            dir = 1'($urandom_range(0, 1));
            pulse_c($sformatf("rnd%0d", i));
        end

        // Reset mid-run with c held high across release
        do_load("ld7", 4'd7);
        en = 1'b0;
        @(posedge clock); #1;
        c = 1'b1;
        @(posedge clock); #1;
        check("pre_rst_q", {12'd0, q}, 16'd7);
        #1 reset = 1'b1;
        #1 check("async_rst_q", {12'd0, q}, 16'd0);
        check("async_rst_co", {15'd0, co}, 16'd0);
        en  = 1'b1;
        dir = 1'b1;
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check($sformatf("c_high_q%0d", i), {12'd0, q}, 16'd0);
        end
        c = 1'b0;
        m_cnt = '0;
        repeat (2) @(posedge clock);
        pulse_c("rst_next");

        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d left expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
